// File: rtl/map_pixel_fetch_pkg.sv
// Shared widths, types and the tile pixel image for the tile-map pixel fetch path.
// The tile image is produced by a function so the ROM needs no external memory file.
package map_pkg;
  localparam int TILE_LOG2     = 4;
  localparam int MAP_COLS_LOG2 = 6;
  localparam int MAP_ROWS_LOG2 = 5;
  localparam int TILE_ID_W     = 6;
  localparam int INDEX_W       = 3;
  localparam int SCREEN_W      = 10;

  localparam int MAP_ADDR_W = MAP_ROWS_LOG2 + MAP_COLS_LOG2;    // 11
  localparam int OFF_W      = 2 * TILE_LOG2;                     // {y_off, x_off}
  localparam int ROM_ADDR_W = TILE_ID_W + OFF_W;                 // 14

  typedef logic [TILE_ID_W-1:0]  tile_id_t;
  typedef logic [INDEX_W-1:0]    pal_index_t;
  typedef logic [OFF_W-1:0]      texel_off_t;
  typedef logic [ROM_ADDR_W-1:0] rom_addr_t;

  // Tile image: addr = {tile_id[5:0], y_off[3:0], x_off[3:0]}.
  function automatic pal_index_t tile_texel(input rom_addr_t a);
    pal_index_t base;
    base = a[10:8] ^ a[13:11] ^ 3'd6;
    return base + a[2:0] + {a[5:4], 1'b0} + {2'b00, a[3] ^ a[6] ^ a[7]};
  endfunction
endpackage

// File: rtl/map_pixel_fetch_if.sv
// Pixel-fetch bus: VGA coordinates in, palette index out, plus scroll and tile-map write port.
// No handshake: every signal is sampled or updated on every Clk edge; no stalls, no backpressure.
interface map_pixel_fetch_if;
  import map_pkg::*;

  logic [SCREEN_W-1:0]   DrawX;
  logic [SCREEN_W-1:0]   DrawY;
  logic                  blank_in;
  logic                  frame_start;
  logic [SCREEN_W-1:0]   scroll_x_req;
  logic                  tm_we;
  logic [MAP_ADDR_W-1:0] tm_addr;
  tile_id_t              tm_wdata;
  pal_index_t            palette_index;
  logic                  index_valid;
  logic [SCREEN_W-1:0]   scroll_x_active;

  modport master (
    output DrawX, DrawY, blank_in, frame_start, scroll_x_req, tm_we, tm_addr, tm_wdata,
    input  palette_index, index_valid, scroll_x_active
  );

  modport slave (
    input  DrawX, DrawY, blank_in, frame_start, scroll_x_req, tm_we, tm_addr, tm_wdata,
    output palette_index, index_valid, scroll_x_active
  );
endinterface

// File: rtl/map_pixel_fetch_tile_rom.sv
// 16384x3 tile pixel ROM with a one-cycle synchronous read.
module map_tile_rom
  import map_pkg::*;
(
  input  logic       i_clk,
  input  rom_addr_t  i_addr,
  output pal_index_t o_texel
);
  pal_index_t r_texel;

  always_ff @(posedge i_clk) begin
    r_texel <= tile_texel(i_addr);
  end

  assign o_texel = r_texel;
endmodule

// File: rtl/map_pixel_fetch.sv
// Per-pixel tile-map renderer: scrolled world coordinate -> tile-map RAM -> tile ROM -> palette index.
// Fixed latency: inputs sampled at edge N appear on palette_index/index_valid after edge N+3.
module map_pixel_fetch
  import map_pkg::*;
(
  input logic              Clk,
  input logic              Reset,
  map_pixel_fetch_if.slave bus
);
  logic [SCREEN_W-1:0]   r_scroll_x;
  logic [SCREEN_W-1:0]   w_world_x;
  logic [MAP_ADDR_W-1:0] w_map_raddr;

  logic [MAP_ADDR_W-1:0] r_raddr0;
  texel_off_t            r_off0;
  texel_off_t            r_off1;
  logic                  r_v0;
  logic                  r_v1;
  logic                  r_v2;

  tile_id_t              r_tile_map [0:(1<<MAP_ADDR_W)-1];
  tile_id_t              r_tile_id;
  rom_addr_t             w_rom_addr;
  pal_index_t            w_texel;
  pal_index_t            r_pal;
  logic                  r_index_valid;

  // Horizontal wrap across the 1024-px world falls out of the 10-bit add.
  assign w_world_x   = bus.DrawX + r_scroll_x;
  assign w_map_raddr = {bus.DrawY[8:4], w_world_x[9:4]};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_scroll_x    <= '0;
      r_v0          <= 1'b0;
      r_v1          <= 1'b0;
      r_v2          <= 1'b0;
      r_pal         <= '0;
      r_index_valid <= 1'b0;
    end else begin
      if (bus.frame_start) r_scroll_x <= bus.scroll_x_req;
      r_v0          <= bus.blank_in;
      r_v1          <= r_v0;
      r_v2          <= r_v1;
      r_pal         <= r_v2 ? w_texel : '0;
      r_index_valid <= r_v2;
    end
  end

  always_ff @(posedge Clk) begin
    r_raddr0 <= w_map_raddr;
    r_off0   <= {bus.DrawY[3:0], w_world_x[3:0]};
    r_off1   <= r_off0;
  end

  // Tile-map RAM: the read samples the array before the write lands, so a
  // same-address collision returns the old tile and the new one next cycle.
  always_ff @(posedge Clk) begin
    if (bus.tm_we) r_tile_map[bus.tm_addr] <= bus.tm_wdata;
    r_tile_id <= r_tile_map[r_raddr0];
  end

  assign w_rom_addr = {r_tile_id, r_off1};

  map_tile_rom u_tile_rom (
    .i_clk   (Clk),
    .i_addr  (w_rom_addr),
    .o_texel (w_texel)
  );

  assign bus.palette_index   = r_pal;
  assign bus.index_valid     = r_index_valid;
  assign bus.scroll_x_active = r_scroll_x;
endmodule

// File: tb/tb_map_pixel_fetch.sv
// Directed bench for map_pixel_fetch: driver pushes tagged expectations, a negedge monitor pops and compares.
module tb_map_pixel_fetch;
  import map_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  map_pixel_fetch_if bus();

  map_pixel_fetch dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  // entry = {cycle tag (32), index_valid (1), palette_index (3)}
  logic [35:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [35:0] e;
    if (mon_en) begin
      if (exp_q.size() != 0 && exp_q[0][35:4] == 32'(cyc)) begin
        e = exp_q.pop_front();
        check("pixel {valid,index}", {28'd0, bus.index_valid, bus.palette_index}, {28'd0, e[3:0]});
      end else if (bus.index_valid !== 1'b0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected index_valid @cyc %0d: got %b, expected 0", cyc, bus.index_valid);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic b,
                     input logic ev, input logic [2:0] eidx);
    bus.DrawX    = x;
    bus.DrawY    = y;
    bus.blank_in = b;
    exp_q.push_back({32'(cyc + 4), ev, eidx});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pix(10'd0, 10'd0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic wr(input logic [10:0] a, input logic [5:0] d);
    bus.tm_we    = 1'b1;
    bus.tm_addr  = a;
    bus.tm_wdata = d;
    idle();
    bus.tm_we    = 1'b0;
  endtask

  task automatic set_scroll(input logic [9:0] s);
    bus.scroll_x_req = s;
    bus.frame_start  = 1'b1;
    idle();
    bus.frame_start  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst              = 1'b1;
    bus.DrawX        = '0;
    bus.DrawY        = '0;
    bus.blank_in     = 1'b0;
    bus.frame_start  = 1'b1;
    bus.scroll_x_req = 10'd100;
    bus.tm_we        = 1'b0;
    bus.tm_addr      = '0;
    bus.tm_wdata     = '0;

    // Reset for two cycles with active pixels; frame_start in the first loses to Reset.
    pix(10'd0, 10'd0, 1'b1, 1'b0, 3'd0);
    mon_en = 1'b1;
    check("reset valid", {31'd0, bus.index_valid}, 32'd0);
    check("reset index", {29'd0, bus.palette_index}, 32'd0);
    check("reset scroll vs frame_start", {22'd0, bus.scroll_x_active}, 32'd0);
    bus.frame_start = 1'b0;
    pix(10'd0, 10'd0, 1'b1, 1'b0, 3'd0);
    check("reset valid 2", {31'd0, bus.index_valid}, 32'd0);
    check("reset scroll 2", {22'd0, bus.scroll_x_active}, 32'd0);
    rst = 1'b0;

    // Map: (r0,c0)=5, (r0,c1)=2, (r1,c0)=9, (r0,c63)=3
    wr(11'd0, 6'd5);
    wr(11'd1, 6'd2);
    wr(11'd64, 6'd9);
    wr(11'd63, 6'd3);

    // Basic fetch, scroll 0
    pix(10'd0,  10'd0,  1'b1, 1'b1, 3'd3);  // tile5 (0,0): 3
    pix(10'd3,  10'd2,  1'b1, 1'b1, 3'd2);  // tile5 x3 y2: 3+3+4=10 -> 2
    pix(10'd16, 10'd0,  1'b1, 1'b1, 3'd4);  // tile2 (0,0): 4
    pix(10'd5,  10'd17, 1'b1, 1'b1, 3'd5);  // tile9 x5 y1: 6+5+2=13 -> 5
    pix(10'd3,  10'd2,  1'b0, 1'b0, 3'd0);  // blanked
    pix(10'd100, 10'd480, 1'b0, 1'b0, 3'd0);

    // Scroll latch
    set_scroll(10'd16);
    check("scroll latched 16", {22'd0, bus.scroll_x_active}, 32'd16);
    pix(10'd0, 10'd0, 1'b1, 1'b1, 3'd4);    // world_x 16 -> tile2 x0: 4
    bus.scroll_x_req = 10'd32;
    pix(10'd2, 10'd0, 1'b1, 1'b1, 3'd6);    // world_x 18 -> tile2 x2: 6
    check("scroll ignores req", {22'd0, bus.scroll_x_active}, 32'd16);

    // Wrap-around
    set_scroll(10'd1020);
    check("scroll latched 1020", {22'd0, bus.scroll_x_active}, 32'd1020);
    pix(10'd8, 10'd0, 1'b1, 1'b1, 3'd7);    // world_x 4 -> tile5 x4: 7
    pix(10'd0, 10'd0, 1'b1, 1'b1, 3'd2);    // world_x 1020 -> col63 tile3 x12: 5+4+1=10 -> 2

    // Read/write collision on address 0
    set_scroll(10'd0);
    pix(10'd0, 10'd0, 1'b1, 1'b1, 3'd3);    // read coincides with write below: old tile5
    bus.tm_we    = 1'b1;
    bus.tm_addr  = 11'd0;
    bus.tm_wdata = 6'd7;
    pix(10'd0, 10'd0, 1'b1, 1'b1, 3'd1);    // tile7 (0,0): 7^6=1
    bus.tm_we    = 1'b0;
    pix(10'd0, 10'd0, 1'b1, 1'b1, 3'd1);

    // Mid-frame reset flushes the three in-flight pixels
    pix(10'd0, 10'd0, 1'b1, 1'b0, 3'd0);
    pix(10'd0, 10'd0, 1'b1, 1'b0, 3'd0);
    pix(10'd0, 10'd0, 1'b1, 1'b0, 3'd0);
    rst = 1'b1;
    pix(10'd0, 10'd0, 1'b1, 1'b0, 3'd0);
    rst = 1'b0;
    check("scroll after mid reset", {22'd0, bus.scroll_x_active}, 32'd0);
    pix(10'd0, 10'd0, 1'b1, 1'b1, 3'd1);

    // Drain
    repeat (4) idle();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
